// File: rtl/alu2_issue_seq.sv
// Command sequencer in front of the 8-bit slice ALU: owns the register file and
// flags, sequences LOAD/ARM/STROBE/WAIT, and writes results back.
module alu2_issue_seq #(
  parameter  int unsigned NREGS   = 4,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src0,
  input  logic [AW-1:0] cmd_src1,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  input  logic          err_clr,
  output logic          done_valid,
  output logic          done_err,
  output logic          err_timeout,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_s,
  output logic          alu_enable,
  output logic          alu_write,
  output logic          alu_strobe,
  output logic [2:0]    alu_opcode,
  output logic [7:0]    alu_operand0,
  output logic [7:0]    alu_operand1,
  output logic          alu_carry,
  input  logic [7:0]    alu_result,
  input  logic          alu_carry_in,
  input  logic          alu_zero,
  input  logic          alu_sign,
  input  logic          alu_ready
);

  localparam int unsigned CW     = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  OP_NOP = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_STROBE,
    S_WAIT,
    S_WB
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_timeout;
  logic            w_wb_en;
  logic [1:0]      r_phase;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_seen_busy;
  logic            r_nop;
  logic [AW-1:0]   r_dst;
  logic [7:0]      r_regs [NREGS];
  logic            r_flag_c;
  logic            r_flag_z;
  logic            r_flag_s;
  logic            r_err_timeout;
  logic            r_done_valid;
  logic            r_done_err;
  logic            r_alu_enable;
  logic            r_alu_write;
  logic            r_alu_strobe;
  logic [2:0]      r_alu_opcode;
  logic [7:0]      r_alu_operand0;
  logic [7:0]      r_alu_operand1;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; an ALU completion in the last WAIT cycle beats the timeout
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_wb_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = (cmd_opcode == OP_NOP) ? S_WB : S_LOAD;
        end
      end
      S_LOAD:   if (r_phase == 2'd2) w_next = S_ARM;
      S_ARM:    if (r_phase == 2'd1) w_next = S_STROBE;
      S_STROBE: w_next = S_WAIT;
      S_WAIT: begin
        if (r_seen_busy && alu_ready) begin
          w_next = S_WB;
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WB: begin
        w_wb_en = !r_nop;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Dwell counters and busy tracking
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase     <= 2'd0;
      r_wait_cnt  <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      r_phase     <= (w_next != r_state) ? 2'd0 : r_phase + 2'd1;
      r_wait_cnt  <= (r_state == S_WAIT && w_next == S_WAIT) ? r_wait_cnt + CW'(1) : '0;
      if (r_state != S_WAIT) r_seen_busy <= 1'b0;
      else if (!alu_ready)   r_seen_busy <= 1'b1;
    end
  end

  // Command capture; the ALU-facing operand registers double as the capture
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_nop          <= 1'b0;
      r_dst          <= '0;
      r_alu_opcode   <= 3'd0;
      r_alu_operand0 <= 8'd0;
      r_alu_operand1 <= 8'd0;
    end else if (w_accept) begin
      r_nop <= (cmd_opcode == OP_NOP);
      r_dst <= cmd_dst;
      if (cmd_opcode != OP_NOP) begin
        r_alu_opcode   <= cmd_opcode;
        r_alu_operand0 <= r_regs[cmd_src0];
        r_alu_operand1 <= r_regs[cmd_src1];
      end
    end
  end

  // Register file; the later writeback assignment overrides a same-index host write
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= 8'd0;
    end else begin
      if (host_we) r_regs[host_addr] <= host_wdata;
      if (w_wb_en) r_regs[r_dst]     <= alu_result;
    end
  end

  // Flags, completion and sticky error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_flag_c      <= 1'b0;
      r_flag_z      <= 1'b0;
      r_flag_s      <= 1'b0;
      r_err_timeout <= 1'b0;
      r_done_valid  <= 1'b0;
      r_done_err    <= 1'b0;
    end else begin
      if (w_wb_en) begin
        r_flag_c <= alu_carry_in;
        r_flag_z <= alu_zero;
        r_flag_s <= alu_sign;
      end
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
      r_done_valid <= (w_next == S_WB) || w_timeout;
      r_done_err   <= w_timeout;
    end
  end

  // ALU control strobes, registered from the upcoming state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_alu_enable <= 1'b0;
      r_alu_write  <= 1'b0;
      r_alu_strobe <= 1'b0;
    end else begin
      r_alu_enable <= (w_next == S_LOAD) || (w_next == S_ARM) ||
                      (w_next == S_STROBE) || (w_next == S_WAIT);
      r_alu_write  <= (w_next == S_LOAD);
      r_alu_strobe <= (w_next == S_STROBE);
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign host_rdata   = r_regs[host_addr];
  assign done_valid   = r_done_valid;
  assign done_err     = r_done_err;
  assign err_timeout  = r_err_timeout;
  assign flag_c       = r_flag_c;
  assign flag_z       = r_flag_z;
  assign flag_s       = r_flag_s;
  assign alu_enable   = r_alu_enable;
  assign alu_write    = r_alu_write;
  assign alu_strobe   = r_alu_strobe;
  assign alu_opcode   = r_alu_opcode;
  assign alu_operand0 = r_alu_operand0;
  assign alu_operand1 = r_alu_operand1;
  assign alu_carry    = r_flag_c;

endmodule

// File: tb/tb_alu2_issue_seq.sv
// Directed bench for alu2_issue_seq with a small behavioural ALU that goes busy
// for three cycles after each strobe, or can be told to never go busy.
module tb_alu2_issue_seq;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_dst, cmd_src0, cmd_src1;
  logic       host_we;
  logic [1:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       err_clr;
  logic       done_valid, done_err, err_timeout;
  logic       flag_c, flag_z, flag_s;
  logic       alu_enable, alu_write, alu_strobe;
  logic [2:0] alu_opcode;
  logic [7:0] alu_operand0, alu_operand1;
  logic       alu_carry;
  logic [7:0] alu_result;
  logic       alu_carry_in, alu_zero, alu_sign, alu_ready;

  int errors = 0;
  int checks = 0;
  int busy;
  bit hang;

  always #5 aclk = ~aclk;

  alu2_issue_seq #(.NREGS(4), .TIMEOUT(15)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .err_clr(err_clr),
    .done_valid(done_valid), .done_err(done_err), .err_timeout(err_timeout),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .alu_enable(alu_enable), .alu_write(alu_write), .alu_strobe(alu_strobe),
    .alu_opcode(alu_opcode), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_carry(alu_carry), .alu_result(alu_result), .alu_carry_in(alu_carry_in),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_ready(alu_ready)
  );

  function automatic logic [8:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
    case (op)
      3'b001:  return 9'(a) + 9'(b) + 9'(c);
      3'b101:  return {c, a & b};
      3'b110:  return {c, a | b};
      3'b111:  return {c, a ^ b};
      default: return {c, a};
    endcase
  endfunction

  // ALU model: busy for three cycles after a strobe, then presents result
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      alu_ready <= 1'b1; busy <= 0; alu_result <= 8'd0;
      alu_carry_in <= 1'b0; alu_zero <= 1'b0; alu_sign <= 1'b0;
    end else if (hang) begin
      alu_ready <= 1'b1;
    end else if (alu_strobe) begin
      alu_ready <= 1'b0; busy <= 3;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        alu_ready <= 1'b1;
        {alu_carry_in, alu_result} <= alu_calc(alu_opcode, alu_operand0, alu_operand1, alu_carry);
        alu_zero <= (alu_calc(alu_opcode, alu_operand0, alu_operand1, alu_carry) & 9'h0FF) == 9'h000;
        alu_sign <= alu_calc(alu_opcode, alu_operand0, alu_operand1, alu_carry) >> 7 & 9'h001;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic hw(input logic [1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    check(tag, host_rdata, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s0,
                       input logic [1:0] s1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_dst = d; cmd_src0 = s0; cmd_src1 = s1;
    check("issue_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Returns the cycle (accept = 0) in which done_valid was seen; bounded
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!done_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check("done_seen", done_valid, 1);
  endtask

  initial begin
    int cyc;
    int rdy_hi;
    int pulses;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_dst = 2'd0;
    cmd_src0 = 2'd0; cmd_src1 = 2'd0; host_we = 1'b0; host_addr = 2'd0;
    host_wdata = 8'd0; err_clr = 1'b0; hang = 1'b0;

    // Reset values
    repeat (2) @(posedge aclk);
    #1;
    check("rst_done", done_valid, 0);
    check("rst_derr", done_err, 0);
    check("rst_etmo", err_timeout, 0);
    check("rst_en", alu_enable, 0);
    check("rst_wr", alu_write, 0);
    check("rst_stb", alu_strobe, 0);
    check("rst_flags", {flag_c, flag_z, flag_s, alu_carry}, 0);
    aresetn = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) rd("rst_reg", 2'(i), 8'h00);

    // ADC r0 <- r1 + r2 with cycle-exact control sequence
    hw(2'd1, 8'h7F);
    hw(2'd2, 8'h01);
    issue(3'b001, 2'd0, 2'd1, 2'd2);
    check("t1_opc", alu_opcode, 3'b001);
    check("t1_op0", alu_operand0, 8'h7F);
    check("t1_op1", alu_operand1, 8'h01);
    for (int c = 1; c <= 10; c++) begin
      check("t1_en", alu_enable, 1);
      check("t1_wr", alu_write, (c <= 3));
      check("t1_stb", alu_strobe, (c == 6));
      check("t1_rdy", cmd_ready, 0);
      check("t1_dv", done_valid, 0);
      tick();
    end
    check("t1_dv11", done_valid, 1);
    check("t1_derr", done_err, 0);
    check("t1_en11", alu_enable, 0);
    tick();
    check("t1_dv_pulse", done_valid, 0);
    check("t1_ready", cmd_ready, 1);
    rd("t1_r0", 2'd0, 8'h80);
    check("t1_czs", {flag_c, flag_z, flag_s}, 3'b001);

    // AND then back-to-back EOR accepted right after done
    hw(2'd1, 8'hF0);
    hw(2'd2, 8'h0F);
    issue(3'b101, 2'd3, 2'd1, 2'd2);
    wait_done(1, cyc);
    check("t2_lat", cyc, 11);
    tick();
    rd("t2_r3", 2'd3, 8'h00);
    check("t2_z", flag_z, 1);
    issue(3'b111, 2'd0, 2'd3, 2'd1);
    wait_done(1, cyc);
    tick();
    rd("t2_r0", 2'd0, 8'hF0);
    check("t2_zs", {flag_z, flag_s}, 2'b01);

    // cmd_valid held high through a busy command; host write after accept
    cmd_valid = 1'b1; cmd_opcode = 3'b001; cmd_dst = 2'd3; cmd_src0 = 2'd1; cmd_src1 = 2'd2;
    check("t3_ready0", cmd_ready, 1);
    tick();
    cmd_opcode = 3'b111; cmd_dst = 2'd0;
    hw(2'd1, 8'h00);
    cyc = 2; rdy_hi = 0;
    while (!done_valid && cyc < 60) begin
      if (cmd_ready) rdy_hi++;
      tick();
      cyc++;
    end
    check("t3_lat", cyc, 11);
    check("t3_rdy_busy", rdy_hi, 0);
    check("t3_rdy_done", cmd_ready, 0);
    tick();
    check("t3_rdy_idle", cmd_ready, 1);
    rd("t3_r3", 2'd3, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    check("t3_rdy_next", cmd_ready, 0);
    check("t3_opc", alu_opcode, 3'b111);
    check("t3_op0", alu_operand0, 8'h00);
    check("t3_op1", alu_operand1, 8'h0F);
    wait_done(1, cyc);
    tick();
    rd("t3_r0", 2'd0, 8'h0F);

    // Timeout: ALU never goes busy
    hw(2'd1, 8'h55);
    hang = 1'b1;
    issue(3'b001, 2'd1, 2'd2, 2'd2);
    wait_done(1, cyc);
    check("t4_lat", cyc, 22);
    check("t4_derr", done_err, 1);
    check("t4_etmo", err_timeout, 1);
    tick();
    check("t4_dv_pulse", done_valid, 0);
    check("t4_sticky", err_timeout, 1);
    check("t4_ready", cmd_ready, 1);
    rd("t4_r1", 2'd1, 8'h55);
    hang = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", err_timeout, 0);

    // Host write and writeback to the same index in the WB cycle
    hw(2'd1, 8'hF0);
    hw(2'd2, 8'h20);
    issue(3'b001, 2'd3, 2'd1, 2'd2);
    repeat (10) tick();
    check("t7_dv", done_valid, 1);
    host_we = 1'b1; host_addr = 2'd3; host_wdata = 8'hAA;
    tick();
    host_we = 1'b0;
    rd("t7_r3", 2'd3, 8'h10);
    check("t7_czs", {flag_c, flag_z, flag_s}, 3'b100);
    check("t7_carry", alu_carry, 1);

    // NOP: done at cycle 1, nothing updated
    hw(2'd2, 8'h3C);
    issue(3'b000, 2'd3, 2'd2, 2'd2);
    check("t6_dv", done_valid, 1);
    check("t6_derr", done_err, 0);
    check("t6_en", alu_enable, 0);
    tick();
    check("t6_dv_pulse", done_valid, 0);
    rd("t6_r3", 2'd3, 8'h10);
    rd("t6_r2", 2'd2, 8'h3C);
    check("t6_czs", {flag_c, flag_z, flag_s}, 3'b100);

    // Reset asserted during WAIT
    issue(3'b001, 2'd0, 2'd1, 2'd2);
    repeat (7) tick();
    aresetn = 1'b0;
    #1;
    check("t5_dv", done_valid, 0);
    check("t5_en", alu_enable, 0);
    check("t5_opc", alu_opcode, 0);
    check("t5_op0", alu_operand0, 0);
    check("t5_flags", {flag_c, flag_z, flag_s}, 0);
    rd("t5_r3_rst", 2'd3, 8'h00);
    tick();
    aresetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_valid) pulses++;
      tick();
    end
    check("t5_nodone", pulses, 0);
    check("t5_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) rd("t5_reg", 2'(i), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
